// File: rtl/frame_pkg.sv
// Shared constants for the serial frame link: sync bytes, frame length,
// scheduler state encoding and the frame check byte.
// Used by frame_scheduler and its sub-modules; no ports.
package frame_pkg;

   localparam logic [7:0] SYNC0     = 8'hFF;
   localparam logic [7:0] SYNC1     = 8'hFE;
   localparam int         FRAME_LEN = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_DAT0,
      ST_DAT1,
      ST_CRC,
      ST_GAP
   } state_t;

   // The link's check byte is a plain XOR of the two data bytes.
   function automatic logic [7:0] crc8_xor(input logic [7:0] d0, input logic [7:0] d1);
      return d0 ^ d1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set req bit searching upward from last_ch+1, wrapping.
// Latency: purely combinational. Backpressure: none, the caller decides when to accept sel.
// Ports: req (N_CH requests), last_ch (previous winner) -> any (some request set), sel (winner index).
module rr_arbiter #(
   parameter int N_CH = 12
) (
   input  logic [N_CH-1:0] req,
   input  logic [3:0]      last_ch,
   output logic            any,
   output logic [3:0]      sel
);

   int idx;

   always_comb begin
      any = 1'b0;
      sel = 4'd0;
      idx = 0;
      // Offsets 1..N_CH visit every channel once, ending on last_ch itself,
      // so a lone requester is always re-granted.
      for (int i = 1; i <= N_CH; i++) begin
         idx = (int'(last_ch) + i) % N_CH;
         if (!any && req[idx]) begin
            any = 1'b1;
            sel = 4'(idx);
         end
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Round-robin scheduler that serialises one channel's 16-bit payload into a 5-byte frame.
// Latency: grant and first sync byte one cycle after req is sampled in IDLE; CRC byte 4 cycles later.
// Backpressure: none on the byte link; channels hold req until granted, req ignored while busy.
// Ports: CLK/RST (async, active-high), req/payload per channel, grant pulse, BYTE_output/byte_valid
//        link bytes, cur_ch owner of current/last frame, busy (not IDLE), frames_sent counter.
module frame_scheduler
   import frame_pkg::*;
#(
   parameter int N_CH       = 12,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_CH-1:0]      req,
   input  logic [16*N_CH-1:0]   payload,
   output logic [N_CH-1:0]      grant,
   output logic [7:0]           BYTE_output,
   output logic                 byte_valid,
   output logic [3:0]           cur_ch,
   output logic                 busy,
   output logic [15:0]          frames_sent
);

   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t          state_q, state_d;
   logic [N_CH-1:0] grant_q, grant_d;
   logic [7:0]      byte_q, byte_d;
   logic            vld_q, vld_d;
   logic [3:0]      cur_ch_q, cur_ch_d;
   logic [3:0]      last_ch_q, last_ch_d;
   logic            busy_q, busy_d;
   logic [15:0]     frames_sent_q, frames_sent_d;
   logic [7:0]      d0_q, d0_d;
   logic [7:0]      d1_q, d1_d;
   logic [GW-1:0]   gap_q, gap_d;

   logic            arb_any;
   logic [3:0]      arb_sel;
   logic [15:0]     sel_payload;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req     (req),
      .last_ch (last_ch_q),
      .any     (arb_any),
      .sel     (arb_sel)
   );

   assign sel_payload = payload[{arb_sel, 4'h0} +: 16];

   // Outputs are registered one state ahead: the byte computed on the edge that
   // enters a state is the byte shown while in that state.
   always_comb begin
      state_d       = state_q;
      grant_d       = '0;
      byte_d        = 8'h00;
      vld_d         = 1'b0;
      cur_ch_d      = cur_ch_q;
      last_ch_d     = last_ch_q;
      frames_sent_d = frames_sent_q;
      d0_d          = d0_q;
      d1_d          = d1_q;
      gap_d         = gap_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d   = {{(N_CH-1){1'b0}}, 1'b1} << arb_sel;
               d0_d      = sel_payload[15:8];
               d1_d      = sel_payload[7:0];
               cur_ch_d  = arb_sel;
               last_ch_d = arb_sel;
               byte_d    = SYNC0;
               vld_d     = 1'b1;
               state_d   = ST_HDR0;
            end
         end
         ST_HDR0: begin
            byte_d  = SYNC1;
            vld_d   = 1'b1;
            state_d = ST_HDR1;
         end
         ST_HDR1: begin
            byte_d  = d0_q;
            vld_d   = 1'b1;
            state_d = ST_DAT0;
         end
         ST_DAT0: begin
            byte_d  = d1_q;
            vld_d   = 1'b1;
            state_d = ST_DAT1;
         end
         ST_DAT1: begin
            byte_d  = crc8_xor(d0_q, d1_q);
            vld_d   = 1'b1;
            state_d = ST_CRC;
         end
         ST_CRC: begin
            frames_sent_d = frames_sent_q + 16'd1;
            gap_d         = GW'(GAP_CYCLES);
            state_d       = ST_GAP;
         end
         ST_GAP: begin
            // Count 1 is the last gap cycle; GAP therefore lasts GAP_CYCLES cycles.
            if (gap_q == GW'(1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         byte_q        <= 8'h00;
         vld_q         <= 1'b0;
         cur_ch_q      <= 4'd0;
         last_ch_q     <= 4'(N_CH - 1);
         busy_q        <= 1'b0;
         frames_sent_q <= 16'd0;
         d0_q          <= 8'h00;
         d1_q          <= 8'h00;
         gap_q         <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         byte_q        <= byte_d;
         vld_q         <= vld_d;
         cur_ch_q      <= cur_ch_d;
         last_ch_q     <= last_ch_d;
         busy_q        <= busy_d;
         frames_sent_q <= frames_sent_d;
         d0_q          <= d0_d;
         d1_q          <= d1_d;
         gap_q         <= gap_d;
      end
   end

   assign grant       = grant_q;
   assign BYTE_output = byte_q;
   assign byte_valid  = vld_q;
   assign cur_ch      = cur_ch_q;
   assign busy        = busy_q;
   assign frames_sent = frames_sent_q;

endmodule
